// File: rtl/muxarb4.sv
// muxarb4: four valid/ready sources merged into one registered output slot by a
// round-robin arbiter; defining MUXARB4_FIXPRIO_EN selects fixed priority 0>1>2>3.
module muxarb4 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    input  logic          vld0,
    input  logic          vld1,
    input  logic          vld2,
    input  logic          vld3,
    output logic          rdy0,
    output logic          rdy1,
    output logic          rdy2,
    output logic          rdy3,
    output logic [DW-1:0] dout,
    output logic [1:0]    dout_sel,
    output logic          dout_vld,
    input  logic          dout_rdy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t         state_r;
    slot_t         state_nxt_s;
    logic [DW-1:0] din_s [4];
    logic [3:0]    vld_s;
    logic [3:0]    rdy_s;
    logic [1:0]    start_s;
    logic [1:0]    grant_s;
    logic [1:0]    idx_s;
    logic          found_s;
    logic          take_s;
    logic          any_vld_s;
    logic          accept_s;

    assign din_s[0]  = din0;
    assign din_s[1]  = din1;
    assign din_s[2]  = din2;
    assign din_s[3]  = din3;
    assign vld_s     = {vld3, vld2, vld1, vld0};
    assign take_s    = (state_r == EMPTY) | dout_rdy;
    assign any_vld_s = |vld_s;
    assign accept_s  = take_s & any_vld_s;
    assign dout_vld  = (state_r == FULL);

`ifdef MUXARB4_FIXPRIO_EN
    assign start_s = 2'b00;
`else
    logic [1:0] ptr_r;

    // Round-robin pointer: moves past the granted source only when a word is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 2'b00;
        end else if (accept_s) begin
            ptr_r <= grant_s + 2'b01;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign start_s = ptr_r;
`endif

    // Arbitration: first valid source scanning upward (mod 4) from start_s
    always_comb begin
        grant_s = 2'b00;
        found_s = 1'b0;
        idx_s   = 2'b00;
        for (int k = 0; k < 4; k++) begin
            idx_s = start_s + 2'(k);
            if (!found_s && vld_s[idx_s]) begin
                grant_s = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot ready toward the granted source when the slot can load
    always_comb begin
        rdy_s = 4'b0000;
        if (accept_s) begin
            rdy_s[grant_s] = 1'b1;
        end else begin
            rdy_s = 4'b0000;
        end
    end

    // Reset masks ready immediately so no handshake completes while held in reset
    assign rdy0 = rdy_s[0] & rst_n;
    assign rdy1 = rdy_s[1] & rst_n;
    assign rdy2 = rdy_s[2] & rst_n;
    assign rdy3 = rdy_s[3] & rst_n;

    // Slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Slot next state: an accept always fills; a drain without refill empties
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                end else if (dout_rdy) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // Output data/index: load on accept, otherwise hold (also across a drain)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= {DW{1'b0}};
            dout_sel <= 2'b00;
        end else if (accept_s) begin
            dout     <= din_s[grant_s];
            dout_sel <= grant_s;
        end else begin
            dout     <= dout;
            dout_sel <= dout_sel;
        end
    end

endmodule

// File: tb/tb_muxarb4.sv
// Directed self-checking bench for muxarb4 (default round-robin build).
module tb_muxarb4;

    logic        clk;
    logic        rst_n;
    logic [31:0] din0, din1, din2, din3;
    logic        vld0, vld1, vld2, vld3;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic [31:0] dout;
    logic [1:0]  dout_sel;
    logic        dout_vld;
    logic        dout_rdy;
    logic [3:0]  rdy_v;

    int n_cmp;
    int n_bad;

    muxarb4 #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .vld0(vld0), .vld1(vld1), .vld2(vld2), .vld3(vld3),
        .rdy0(rdy0), .rdy1(rdy1), .rdy2(rdy2), .rdy3(rdy3),
        .dout(dout), .dout_sel(dout_sel), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy)
    );

    assign rdy_v = {rdy3, rdy2, rdy1, rdy0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] d, input logic [1:0] s, input logic v);
        chk({tag, "_dout"}, dout, d);
        chk({tag, "_sel"}, 32'(dout_sel), 32'(s));
        chk({tag, "_vld"}, 32'(dout_vld), 32'(v));
    endtask

    initial begin
        logic [3:0] exp_rdy;
        logic [1:0] exp_sel;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        din0 = 32'h0; din1 = 32'h0; din2 = 32'h0; din3 = 32'h0;
        vld0 = 1'b1; vld1 = 1'b0; vld2 = 1'b0; vld3 = 1'b0;
        dout_rdy = 1'b1;
        #2;
        chk_slot("rst", 32'h0, 2'd0, 1'b0);
        chk("rst_rdy", 32'(rdy_v), 32'h0);
        vld0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // round-robin: all four sources valid, sink always ready
        din0 = 32'h1000_0000; din1 = 32'h1000_0001; din2 = 32'h1000_0002; din3 = 32'h1000_0003;
        {vld3, vld2, vld1, vld0} = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_rdy = 4'b0001 << (k % 4);
            chk("rr_rdy", 32'(rdy_v), 32'(exp_rdy));
            if (k > 0) begin
                exp_sel = 2'((k - 1) % 4);
                chk_slot("rr", 32'h1000_0000 | 32'(exp_sel), exp_sel, 1'b1);
            end
            tick();
        end
        {vld3, vld2, vld1, vld0} = 4'b0000;
        @(negedge clk);
        chk_slot("rr_last", 32'h1000_0003, 2'd3, 1'b1);
        chk("idle_rdy", 32'(rdy_v), 32'h0);
        tick();

        // drain happened on that edge; single source 2 now
        din2 = 32'hA5A5_0002;
        vld2 = 1'b1;
        @(negedge clk);
        chk_slot("drain", 32'h1000_0003, 2'd3, 1'b0);
        chk("single_rdy", 32'(rdy_v), 32'h4);
        tick();

        // ptr is 3: with 0 and 3 valid, source 3 wins first
        vld2 = 1'b0;
        din0 = 32'hB000_0000; din3 = 32'hB000_0003;
        vld0 = 1'b1; vld3 = 1'b1;
        @(negedge clk);
        chk_slot("single", 32'hA5A5_0002, 2'd2, 1'b1);
        chk("ptr3_rdy", 32'(rdy_v), 32'h8);
        tick();
        @(negedge clk);
        chk_slot("wrap3", 32'hB000_0003, 2'd3, 1'b1);
        chk("wrap_rdy", 32'(rdy_v), 32'h1);
        tick();

        // drain without refill
        vld0 = 1'b0; vld3 = 1'b0;
        @(negedge clk);
        chk_slot("wrap0", 32'hB000_0000, 2'd0, 1'b1);
        tick();
        @(negedge clk);
        chk_slot("drain2", 32'hB000_0000, 2'd0, 1'b0);
        tick();

        // fill slot from source 1 (ptr=1) with sink stalled
        dout_rdy = 1'b0;
        din1 = 32'hC000_0001;
        vld1 = 1'b1;
        @(negedge clk);
        chk("fill_rdy", 32'(rdy_v), 32'h2);
        tick();

        // backpressure: 0 and 3 valid, slot full, sink stalled
        vld1 = 1'b0;
        din0 = 32'hD000_0000; din3 = 32'hD000_0003;
        vld0 = 1'b1; vld3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rdy", 32'(rdy_v), 32'h0);
            chk_slot("bp", 32'hC000_0001, 2'd1, 1'b1);
            tick();
        end
        dout_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rel_rdy", 32'(rdy_v), 32'h8);
        tick();
        vld3 = 1'b0;
        dout_rdy = 1'b0;
        @(negedge clk);
        chk_slot("bp_out", 32'hD000_0003, 2'd3, 1'b1);

        // asynchronous reset mid-clock while the slot is full
        #1;
        rst_n = 1'b0;
        #1;
        chk_slot("arst", 32'h0, 2'd0, 1'b0);
        chk("arst_rdy", 32'(rdy_v), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_vld", 32'(dout_vld), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", 32'(rdy_v), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
